id_ex_stage: RTL and testbench

- ID/EX pipeline register of the pipelined MIPS core; sits directly upstream of the ALU.
- Latches decoded operands and control from ID and decodes `alu_op`/`funct` into the 4-bit ALU control code.
- Applies EX/MEM and MEM/WB forwarding to produce `alu_a`/`alu_b`.
- Handles stall (hold) and flush (bubble), and flags load-use hazards to the hazard unit.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/alu_ctrl_decode.sv | 37 +++
 rtl/id_ex_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: ALU control codes, alu_op
// encodings, R-type funct values and the ID/EX bubble control bundle.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_OR    = 2'b11
    } alu_op_t;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       illegal;
        logic [3:0] alu_control;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '{
        valid:       1'b0,
        reg_write:   1'b0,
        mem_read:    1'b0,
        mem_write:   1'b0,
        mem_to_reg:  1'b0,
        alu_src:     1'b0,
        illegal:     1'b0,
        alu_control: ALU_ADD
    };

endpackage

// File: rtl/alu_ctrl_decode.sv
// Maps (alu_op, funct) to the 4-bit ALU control code; unknown R-type funct
// falls back to add and raises illegal.
import mips_pkg::*;

module alu_ctrl_decode (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op_t'(alu_op))
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_OR:  alu_control = ALU_OR;
            ALU_OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_NOR: alu_control = ALU_NOR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default: begin
                        alu_control = ALU_ADD;
                        illegal     = 1'b1;
                    end
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands/control, applies
// EX/MEM and MEM/WB forwarding, and flags load-use hazards.
import mips_pkg::*;

module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [4:0]        exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [4:0]        ex_dest,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_illegal,
    output logic              load_use_hazard
);

    ctrl_t             ctrl_q;
    logic [4:0]        rs_q;
    logic [4:0]        rt_q;
    logic [4:0]        dest_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;

    logic [3:0]        dec_control;
    logic              dec_illegal;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    alu_ctrl_decode u_alu_ctrl_decode (
        .alu_op      (id_alu_op),
        .funct       (id_funct),
        .alu_control (dec_control),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ctrl_q    <= BUBBLE_CTRL;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else if (!stall) begin
            ctrl_q.valid       <= id_valid;
            ctrl_q.reg_write   <= id_reg_write;
            ctrl_q.mem_read    <= id_mem_read;
            ctrl_q.mem_write   <= id_mem_write;
            ctrl_q.mem_to_reg  <= id_mem_to_reg;
            ctrl_q.alu_src     <= id_alu_src;
            ctrl_q.illegal     <= dec_illegal;
            ctrl_q.alu_control <= dec_control;
            rs_q               <= id_rs;
            rt_q               <= id_rt;
            dest_q             <= id_reg_dst ? id_rd : id_rt;
            rs_data_q          <= id_rs_data;
            rt_data_q          <= id_rt_data;
            imm_q              <= id_imm;
        end
    end

    // EX/MEM wins over MEM/WB; a zero rd on either source never forwards.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [4:0]        src,
        input logic [DATA_W-1:0] reg_data,
        input logic              em_we,
        input logic [4:0]        em_rd,
        input logic [DATA_W-1:0] em_res,
        input logic              mw_we,
        input logic [4:0]        mw_rd,
        input logic [DATA_W-1:0] mw_res
    );
        if (em_we && em_rd != 5'd0 && em_rd == src)
            return em_res;
        else if (mw_we && mw_rd != 5'd0 && mw_rd == src)
            return mw_res;
        else
            return reg_data;
    endfunction

    always_comb begin
        fwd_rs = fwd_sel(rs_q, rs_data_q, exmem_reg_write, exmem_rd, exmem_result,
                         memwb_reg_write, memwb_rd, memwb_result);
        fwd_rt = fwd_sel(rt_q, rt_data_q, exmem_reg_write, exmem_rd, exmem_result,
                         memwb_reg_write, memwb_rd, memwb_result);
    end

    assign alu_a         = fwd_rs;
    assign ex_store_data = fwd_rt;
    assign alu_b         = ctrl_q.alu_src ? imm_q : fwd_rt;
    assign alu_control   = ctrl_q.alu_control;
    assign ex_dest       = dest_q;
    assign ex_valid      = ctrl_q.valid;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_illegal    = ctrl_q.illegal;

    assign load_use_hazard = ctrl_q.valid && ctrl_q.mem_read && (dest_q != 5'd0) && id_valid
                             && ((dest_q == id_rs) || (dest_q == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX-side values are queued when
// an ID instruction is driven and compared one edge later.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;
    logic        load_use_hazard;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a, b, store;
        logic [3:0]  ctl;
        logic [4:0]  dest;
        logic        valid, rw, mr, mw, m2r, ill;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_illegal(ex_illegal), .load_use_hazard(load_use_hazard)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic [1:0] op, input logic [5:0] fn, input logic src, input logic dst,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_op = op; id_funct = fn; id_alu_src = src; id_reg_dst = dst;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                        input logic [3:0] ctl, input logic [4:0] dest, input logic v,
                        input logic rw, input logic mr, input logic mw, input logic m2r, input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.store = st; e.ctl = ctl; e.dest = dest;
        e.valid = v; e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r; e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        check({name, ".sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({name, ".alu_a"}, alu_a, e.a);
        check({name, ".alu_b"}, alu_b, e.b);
        check({name, ".store"}, ex_store_data, e.store);
        check({name, ".alu_control"}, 32'(alu_control), 32'(e.ctl));
        check({name, ".dest"}, 32'(ex_dest), 32'(e.dest));
        check({name, ".ctrl"}, {26'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal},
              {26'd0, e.valid, e.rw, e.mr, e.mw, e.m2r, e.ill});
    endtask

    task automatic fwd_off();
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
    endtask

    logic [5:0] functs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    logic [3:0] codes  [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        fwd_off();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'hDEAD, 32'hBEEF, 32'h44, 2'b10, 6'b100010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        push(32'd0, 32'd0, 32'd0, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pop_compare("reset");
        reset = 1'b0;

        // R-type decode, no forwarding
        for (int i = 0; i < 6; i++) begin
            set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd7, 32'd3, 32'h99, 2'b10, functs[i], 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            push(32'd7, 32'd3, 32'd3, codes[i], 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            pop_compare($sformatf("rtype%0d", i));
        end
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd7, 32'd3, 32'h99, 2'b10, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(32'd7, 32'd3, 32'd3, 4'b0010, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        pop_compare("illegal");
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd7, 32'd3, 32'h99, 2'b11, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(32'd7, 32'h99, 32'd3, 4'b0001, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pop_compare("ori");

        // Forwarding priority on rs
        set_id(1'b1, 5'd5, 5'd6, 5'd0, 32'h1111, 32'h2222, 32'h0, 2'b00, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(32'h1111, 32'h2222, 32'h2222, 4'b0010, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pop_compare("fwd_base");
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAAAA;
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hBBBB;
        #1 check("fwd_exmem_prio", alu_a, 32'hAAAA);
        check("fwd_rt_untouched", alu_b, 32'h2222);
        exmem_reg_write = 1'b0;
        #1 check("fwd_memwb", alu_a, 32'hBBBB);
        memwb_rd = 5'd6;
        #1 check("fwd_memwb_rt", ex_store_data, 32'hBBBB);
        fwd_off();
        set_id(1'b1, 5'd0, 5'd6, 5'd0, 32'h1234, 32'h2222, 32'h0, 2'b00, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(32'h1234, 32'h2222, 32'h2222, 4'b0010, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pop_compare("rs0_load");
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h9999;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'h8888;
        #1 check("fwd_r0_never", alu_a, 32'h1234);
        fwd_off();

        // Store: immediate on alu_b, forwarded rt on store data
        exmem_reg_write = 1'b1; exmem_rd = 5'd8; exmem_result = 32'h55;
        set_id(1'b1, 5'd9, 5'd8, 5'd0, 32'h20, 32'h77, 32'h10, 2'b00, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(32'h20, 32'h10, 32'h55, 4'b0010, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        pop_compare("sw");
        fwd_off();

        // Load-use hazard
        set_id(1'b1, 5'd2, 5'd4, 5'd0, 32'h100, 32'h0, 32'h8, 2'b00, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        push(32'h100, 32'h8, 32'h0, 4'b0010, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        pop_compare("lw4");
        id_rs = 5'd4; id_rt = 5'd7; id_valid = 1'b1;
        #1 check("luh_rs", 32'(load_use_hazard), 32'd1);
        id_valid = 1'b0;
        #1 check("luh_invalid", 32'(load_use_hazard), 32'd0);
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd4;
        #1 check("luh_rt", 32'(load_use_hazard), 32'd1);
        id_rt = 5'd5;
        #1 check("luh_nomatch", 32'(load_use_hazard), 32'd0);
        set_id(1'b1, 5'd2, 5'd0, 5'd0, 32'h100, 32'h0, 32'h8, 2'b00, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        push(32'h100, 32'h8, 32'h0, 4'b0010, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        pop_compare("lw0");
        id_rs = 5'd0; id_rt = 5'd0; id_valid = 1'b1;
        #1 check("luh_dest0", 32'(load_use_hazard), 32'd0);

        // Stall holds for three cycles while ID changes underneath
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd7, 32'd3, 32'h0, 2'b10, 6'b100010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(32'd7, 32'd3, 32'd3, 4'b0110, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pop_compare("pre_stall");
        stall = 1'b1;
        set_id(1'b1, 5'd10, 5'd11, 5'd9, 32'h5, 32'h6, 32'h7, 2'b10, 6'b100100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            push(32'd7, 32'd3, 32'd3, 4'b0110, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            pop_compare($sformatf("stall%0d", c));
        end

        // Reset while stalled discards the held instruction
        reset = 1'b1;
        push(32'd0, 32'd0, 32'd0, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pop_compare("reset_in_stall");
        reset = 1'b0; stall = 1'b0;

        // Flush together with stall gives a bubble
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd7, 32'd3, 32'h0, 2'b10, 6'b101010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(32'd7, 32'd3, 32'd3, 4'b0111, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pop_compare("pre_flush");
        stall = 1'b1; flush = 1'b1;
        push(32'd0, 32'd0, 32'd0, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        pop_compare("flush_stall");
        stall = 1'b0; flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
